alu_op_sequencer: RTL and testbench

- Initiator side of the datapath ALU interface.
- Accepts one decoded arithmetic/logic request per handshake, latches its operands and drives the ALU data inputs and control strobes for one or two execute cycles.
- Captures ALU result, carry and overflow, and returns the result with updated N/V/Z/C flags.
- Sits between instruction decode/timing and the ALU. Also computes 16-bit branch/address targets (two ALU passes) with a page-cross indication.

---
 rtl/alu_seq_pkg.sv | 82 ++++++++
 rtl/alu_op_sequencer_decode.sv | 110 +++++++++++
 rtl/alu_op_sequencer.sv | 146 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU op sequencer: op codes, ALU control word,
// FSM states, flag bit positions and the flag-update helper.
package alu_seq_pkg;

   localparam int OP_W   = 4;
   localparam int DATA_W = 8;

   typedef enum logic [3:0] {
      OP_ADC  = 4'd0,
      OP_SBC  = 4'd1,
      OP_AND  = 4'd2,
      OP_ORA  = 4'd3,
      OP_EOR  = 4'd4,
      OP_ASL  = 4'd5,
      OP_ROL  = 4'd6,
      OP_LSR  = 4'd7,
      OP_ROR  = 4'd8,
      OP_CMP  = 4'd9,
      OP_INC  = 4'd10,
      OP_DEC  = 4'd11,
      OP_ADDW = 4'd12
   } op_t;

   // Field order is the bit order of the alu_ctl port, MSB first.
   typedef struct packed {
      logic ldb_inv_db;
      logic ldb_db;
      logic ldb_adl;
      logic lda_sb;
      logic lda_zero;
      logic enable_dec;
      logic carry_in;
      logic e_sum;
      logic e_and;
      logic e_eor;
      logic e_or;
      logic e_shiftr;
      logic subtracting;
      logic spare;
   } alu_ctl_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXEC_LO = 2'd1,
      ST_EXEC_HI = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_V = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_C = 0;

   // Codes above ADDW have no ALU meaning.
   function automatic logic is_reserved(input logic [3:0] op);
      return (op > OP_ADDW);
   endfunction

   // {N,V,Z,C} after an 8-bit op; ADDW and reserved codes leave flags alone.
   function automatic logic [3:0] next_flags(input logic [3:0] op,
                                             input logic [3:0] fl,
                                             input logic [7:0] res,
                                             input logic       co,
                                             input logic       ov);
      logic [3:0] nf;
      nf = fl;
      if (!is_reserved(op) && (op != OP_ADDW)) begin
         nf[FLAG_N] = res[7];
         nf[FLAG_Z] = (res == 8'h00);
      end
      case (op_t'(op))
         OP_ADC, OP_SBC: begin
            nf[FLAG_C] = co;
            nf[FLAG_V] = ov;
         end
         OP_ASL, OP_ROL, OP_LSR, OP_ROR, OP_CMP: nf[FLAG_C] = co;
         default: ;
      endcase
      return nf;
   endfunction

endpackage

// File: rtl/alu_op_sequencer_decode.sv
// alu_op_decode: combinational map from FSM state and the latched request
// to the ALU control word and data drives. Everything is zero outside the
// execute states. Decimal mode is compiled in with ALU_SEQ_DECIMAL_EN.
module alu_op_decode
   import alu_seq_pkg::*;
(
   input  logic [1:0]  state,
   input  logic [3:0]  op,
   input  logic [7:0]  a,
   input  logic [7:0]  a_hi,
   input  logic [7:0]  b,
   input  logic        c_in,
   input  logic        d_in,
   input  logic        lo_carry,
   output logic [13:0] ctl,
   output logic [7:0]  sb,
   output logic [7:0]  db,
   output logic [7:0]  adl
);

   alu_ctl_t ctl_s;

`ifndef ALU_SEQ_DECIMAL_EN
   // Binary-only build: the D flag has no effect.
   logic unused_dec;
   assign unused_dec = d_in;
`endif

   // The ADL bus is not used by any supported operation.
   assign adl = 8'h00;
   assign ctl = ctl_s;

   // Per-state, per-op ALU drive selection.
   always_comb begin
      ctl_s = '0;
      sb    = 8'h00;
      db    = 8'h00;
      if (state_t'(state) == ST_EXEC_LO) begin
         case (op_t'(op))
            OP_ADC: begin
               sb = a; db = b;
               ctl_s.lda_sb = 1'b1; ctl_s.ldb_db = 1'b1;
               ctl_s.e_sum = 1'b1; ctl_s.carry_in = c_in;
`ifdef ALU_SEQ_DECIMAL_EN
               ctl_s.enable_dec = d_in;
`endif
            end
            OP_SBC: begin
               sb = a; db = b;
               ctl_s.lda_sb = 1'b1; ctl_s.ldb_inv_db = 1'b1;
               ctl_s.e_sum = 1'b1; ctl_s.carry_in = c_in;
               ctl_s.subtracting = 1'b1;
`ifdef ALU_SEQ_DECIMAL_EN
               ctl_s.enable_dec = d_in;
`endif
            end
            OP_AND, OP_ORA, OP_EOR: begin
               sb = a; db = b;
               ctl_s.lda_sb = 1'b1; ctl_s.ldb_db = 1'b1;
               ctl_s.e_and = (op_t'(op) == OP_AND);
               ctl_s.e_or  = (op_t'(op) == OP_ORA);
               ctl_s.e_eor = (op_t'(op) == OP_EOR);
            end
            // Left shift is a + a (+ C for rotate).
            OP_ASL, OP_ROL: begin
               sb = a; db = a;
               ctl_s.lda_sb = 1'b1; ctl_s.ldb_db = 1'b1;
               ctl_s.e_sum = 1'b1;
               ctl_s.carry_in = (op_t'(op) == OP_ROL) ? c_in : 1'b0;
            end
            OP_LSR, OP_ROR: begin
               sb = a;
               ctl_s.lda_sb = 1'b1; ctl_s.e_shiftr = 1'b1;
               ctl_s.carry_in = (op_t'(op) == OP_ROR) ? c_in : 1'b0;
            end
            OP_CMP: begin
               sb = a; db = b;
               ctl_s.lda_sb = 1'b1; ctl_s.ldb_inv_db = 1'b1;
               ctl_s.e_sum = 1'b1; ctl_s.carry_in = 1'b1;
            end
            OP_INC: begin
               sb = a;
               ctl_s.lda_sb = 1'b1; ctl_s.ldb_db = 1'b1;
               ctl_s.e_sum = 1'b1; ctl_s.carry_in = 1'b1;
            end
            // a + 0xFF = a - 1
            OP_DEC: begin
               sb = a;
               ctl_s.lda_sb = 1'b1; ctl_s.ldb_inv_db = 1'b1;
               ctl_s.e_sum = 1'b1;
            end
            OP_ADDW: begin
               sb = a; db = b;
               ctl_s.lda_sb = 1'b1; ctl_s.ldb_db = 1'b1;
               ctl_s.e_sum = 1'b1;
            end
            default: ;
         endcase
      end else if ((state_t'(state) == ST_EXEC_HI) && (op_t'(op) == OP_ADDW)) begin
         // Sign-extend the offset: add 0x00 or 0xFF plus the low-byte carry.
         sb = a_hi;
         ctl_s.lda_sb     = 1'b1;
         ctl_s.ldb_db     = ~b[7];
         ctl_s.ldb_inv_db = b[7];
         ctl_s.e_sum      = 1'b1;
         ctl_s.carry_in   = lo_carry;
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one ALU request, drives the ALU for one
// (8-bit ops) or two (ADDW) execute cycles, and returns result and flags.
// Optional decimal mode: ALU_SEQ_DECIMAL_EN.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int OP_W   = 4,
   parameter int DATA_W = 8
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [OP_W-1:0]   op_code,
   input  logic [DATA_W-1:0] operand_a,
   input  logic [DATA_W-1:0] operand_a_hi,
   input  logic [DATA_W-1:0] operand_b,
   input  logic [3:0]        flags_in,
   input  logic              dec_flag,
   output logic [DATA_W-1:0] alu_sb,
   output logic [DATA_W-1:0] alu_db,
   output logic [DATA_W-1:0] alu_adl,
   output logic [13:0]       alu_ctl,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_carry_out,
   input  logic              alu_overflow,
   output logic              res_valid,
   output logic [15:0]       result,
   output logic [3:0]        flags_out,
   output logic              page_cross,
   output logic              illegal_op
);

   state_t              state_q, state_d;
   logic [OP_W-1:0]     op_q, op_d;
   logic [DATA_W-1:0]   a_q, a_d, ahi_q, ahi_d, b_q, b_d;
   logic [3:0]          flg_q, flg_d;
   logic                dec_q, dec_d;
   logic [DATA_W-1:0]   lo_q, lo_d;
   logic                lo_c_q, lo_c_d;
   logic [15:0]         result_q, result_d;
   logic [3:0]          flags_out_q, flags_out_d;
   logic                page_cross_q, page_cross_d;

   alu_op_decode u_decode (
      .state    (state_q),
      .op       (op_q),
      .a        (a_q),
      .a_hi     (ahi_q),
      .b        (b_q),
      .c_in     (flg_q[FLAG_C]),
      .d_in     (dec_q),
      .lo_carry (lo_c_q),
      .ctl      (alu_ctl),
      .sb       (alu_sb),
      .db       (alu_db),
      .adl      (alu_adl)
   );

   assign op_ready   = (state_q == ST_IDLE);
   assign res_valid  = (state_q == ST_DONE);
   assign illegal_op = res_valid & is_reserved(op_q);
   assign result     = result_q;
   assign flags_out  = flags_out_q;
   assign page_cross = page_cross_q;

   // Next state, request latch and result capture at the end of each EXEC cycle.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      a_d          = a_q;
      ahi_d        = ahi_q;
      b_d          = b_q;
      flg_d        = flg_q;
      dec_d        = dec_q;
      lo_d         = lo_q;
      lo_c_d       = lo_c_q;
      result_d     = result_q;
      flags_out_d  = flags_out_q;
      page_cross_d = page_cross_q;
      case (state_q)
         ST_IDLE: begin
            if (op_valid) begin
               op_d    = op_code;
               a_d     = operand_a;
               ahi_d   = operand_a_hi;
               b_d     = operand_b;
               flg_d   = flags_in;
               dec_d   = dec_flag;
               state_d = ST_EXEC_LO;
            end
         end
         ST_EXEC_LO: begin
            lo_d   = alu_out;
            lo_c_d = alu_carry_out;
            if (op_q == OP_ADDW) begin
               state_d = ST_EXEC_HI;
            end else begin
               state_d      = ST_DONE;
               result_d     = {8'h00, is_reserved(op_q) ? a_q : alu_out};
               flags_out_d  = next_flags(op_q, flg_q, alu_out, alu_carry_out, alu_overflow);
               page_cross_d = 1'b0;
            end
         end
         ST_EXEC_HI: begin
            state_d      = ST_DONE;
            result_d     = {alu_out, lo_q};
            flags_out_d  = flg_q;
            page_cross_d = (alu_out != ahi_q);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and capture registers; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         op_q         <= '0;
         a_q          <= '0;
         ahi_q        <= '0;
         b_q          <= '0;
         flg_q        <= '0;
         dec_q        <= 1'b0;
         lo_q         <= '0;
         lo_c_q       <= 1'b0;
         result_q     <= '0;
         flags_out_q  <= '0;
         page_cross_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         a_q          <= a_d;
         ahi_q        <= ahi_d;
         b_q          <= b_d;
         flg_q        <= flg_d;
         dec_q        <= dec_d;
         lo_q         <= lo_d;
         lo_c_q       <= lo_c_d;
         result_q     <= result_d;
         flags_out_q  <= flags_out_d;
         page_cross_q <= page_cross_d;
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU, table-driven requests with a
// scoreboard queue, plus reset-abort and held-valid sequences.
module tb_alu_op_sequencer;
   import alu_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid, op_ready;
   logic [3:0]  op_code;
   logic [7:0]  operand_a, operand_a_hi, operand_b;
   logic [3:0]  flags_in;
   logic        dec_flag;
   logic [7:0]  alu_sb, alu_db, alu_adl;
   logic [13:0] alu_ctl;
   logic [7:0]  alu_out;
   logic        alu_carry_out, alu_overflow;
   logic        res_valid;
   logic [15:0] result;
   logic [3:0]  flags_out;
   logic        page_cross, illegal_op;

   int cmps = 0;
   int errs = 0;
   int cyc  = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_op_sequencer dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
      .op_code(op_code), .operand_a(operand_a), .operand_a_hi(operand_a_hi),
      .operand_b(operand_b), .flags_in(flags_in), .dec_flag(dec_flag),
      .alu_sb(alu_sb), .alu_db(alu_db), .alu_adl(alu_adl), .alu_ctl(alu_ctl),
      .alu_out(alu_out), .alu_carry_out(alu_carry_out), .alu_overflow(alu_overflow),
      .res_valid(res_valid), .result(result), .flags_out(flags_out),
      .page_cross(page_cross), .illegal_op(illegal_op)
   );

   // Behavioural ALU responding to the sequencer's drives.
   alu_ctl_t   cv;
   logic [7:0] ain, bin;
   logic [8:0] sum;
   logic [5:0] dlo, dhi;
   assign cv = alu_ctl;
   always_comb begin
      ain = cv.lda_sb ? alu_sb : 8'h00;
      bin = cv.ldb_db ? alu_db : cv.ldb_inv_db ? ~alu_db : cv.ldb_adl ? alu_adl : 8'h00;
      sum = {1'b0, ain} + {1'b0, bin} + {8'h00, cv.carry_in};
      dlo = 6'd0;
      dhi = 6'd0;
      alu_out = 8'h00; alu_carry_out = 1'b0; alu_overflow = 1'b0;
      if (cv.e_sum) begin
         alu_out       = sum[7:0];
         alu_carry_out = sum[8];
         alu_overflow  = (ain[7] == bin[7]) && (sum[7] != ain[7]);
         if (cv.enable_dec) begin
            alu_overflow = 1'b0;
            if (!cv.subtracting) begin
               dlo = {2'b0, ain[3:0]} + {2'b0, bin[3:0]} + {5'b0, cv.carry_in};
               if (dlo > 6'd9) dlo = dlo + 6'd6;
               dhi = {2'b0, ain[7:4]} + {2'b0, bin[7:4]} + {5'b0, (dlo >= 6'd16)};
               if (dhi > 6'd9) dhi = dhi + 6'd6;
               alu_out       = {dhi[3:0], dlo[3:0]};
               alu_carry_out = (dhi >= 6'd16);
            end else begin
               dlo = {2'b0, ain[3:0]} + {2'b0, bin[3:0]} + {5'b0, cv.carry_in};
               if (dlo < 6'd16) alu_out = alu_out - 8'h06;
               if (!sum[8]) alu_out = alu_out - 8'h60;
            end
         end
      end else if (cv.e_and) alu_out = ain & bin;
      else if (cv.e_or)  alu_out = ain | bin;
      else if (cv.e_eor) alu_out = ain ^ bin;
      else if (cv.e_shiftr) begin
         alu_out       = {cv.carry_in, ain[7:1]};
         alu_carry_out = ain[0];
      end
   end

   typedef struct {
      logic [3:0]  op;
      logic [7:0]  a, ahi, b;
      logic [3:0]  fl;
      logic        d;
      logic [15:0] res;
      logic [3:0]  fo;
      logic        pc, ill;
      int          lat;
   } vec_t;

   typedef struct {
      logic [15:0] res;
      logic [3:0]  fo;
      logic        pc, ill;
      int          acc;   // cycle in which the request was presented
      int          lat;
   } exp_t;

   exp_t sbq[$];
   vec_t vecs[19];

`ifdef ALU_SEQ_DECIMAL_EN
   localparam logic [15:0] DEC_EXP = 16'h0020;
`else
   localparam logic [15:0] DEC_EXP = 16'h001A;
`endif

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      cmps++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (!op_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!op_ready) begin
         cmps++; errs++;
         $display("FAIL ready_timeout: op_ready still low after %0d cycles", n);
      end
   endtask

   task automatic present(input vec_t v);
      op_code = v.op; operand_a = v.a; operand_a_hi = v.ahi; operand_b = v.b;
      flags_in = v.fl; dec_flag = v.d; op_valid = 1'b1;
   endtask

   task automatic send(input vec_t v);
      exp_t e;
      wait_ready();
      present(v);
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      e.res = v.res; e.fo = v.fo; e.pc = v.pc; e.ill = v.ill;
      e.acc = cyc - 1; e.lat = v.lat;
      sbq.push_back(e);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drain", 16'(sbq.size()), 16'd0);
   endtask

   // Scoreboard monitor: every res_valid pops one expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && res_valid) begin
            if (sbq.size() == 0) begin
               cmps++; errs++;
               $display("FAIL unexpected_res_valid: got result %h with no request pending", result);
            end else begin
               e = sbq.pop_front();
               chk("result", result, e.res);
               chk("flags_out", 16'(flags_out), 16'(e.fo));
               chk("page_cross", 16'(page_cross), 16'(e.pc));
               chk("illegal_op", 16'(illegal_op), 16'(e.ill));
               chk("latency", 16'(cyc - e.acc), 16'(e.lat));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      vec_t h;
      //          op     a      ahi    b      fl       d     res       fo       pc    ill   lat
      vecs[0]  = '{4'd0,  8'h50, 8'h00, 8'h50, 4'b0000, 1'b0, 16'h00A0, 4'b1100, 1'b0, 1'b0, 2};
      vecs[1]  = '{4'd1,  8'h00, 8'h00, 8'h01, 4'b0001, 1'b0, 16'h00FF, 4'b1000, 1'b0, 1'b0, 2};
      vecs[2]  = '{4'd9,  8'h40, 8'h00, 8'h40, 4'b0100, 1'b0, 16'h0000, 4'b0111, 1'b0, 1'b0, 2};
      vecs[3]  = '{4'd12, 8'hF0, 8'h12, 8'h20, 4'b1010, 1'b0, 16'h1310, 4'b1010, 1'b1, 1'b0, 3};
      vecs[4]  = '{4'd12, 8'h00, 8'h10, 8'h80, 4'b0000, 1'b0, 16'h0F80, 4'b0000, 1'b1, 1'b0, 3};
      vecs[5]  = '{4'd12, 8'h00, 8'h10, 8'h05, 4'b0101, 1'b0, 16'h1005, 4'b0101, 1'b0, 1'b0, 3};
      vecs[6]  = '{4'd8,  8'h01, 8'h00, 8'h00, 4'b0001, 1'b0, 16'h0080, 4'b1001, 1'b0, 1'b0, 2};
      vecs[7]  = '{4'd5,  8'h80, 8'h00, 8'h00, 4'b0000, 1'b0, 16'h0000, 4'b0011, 1'b0, 1'b0, 2};
      vecs[8]  = '{4'd0,  8'h19, 8'h00, 8'h01, 4'b0000, 1'b1, DEC_EXP,  4'b0000, 1'b0, 1'b0, 2};
      vecs[9]  = '{4'd14, 8'h5A, 8'h00, 8'h00, 4'b1101, 1'b0, 16'h005A, 4'b1101, 1'b0, 1'b1, 2};
      vecs[10] = '{4'd2,  8'hF0, 8'h00, 8'h3C, 4'b1111, 1'b0, 16'h0030, 4'b0101, 1'b0, 1'b0, 2};
      vecs[11] = '{4'd3,  8'h00, 8'h00, 8'h00, 4'b1000, 1'b0, 16'h0000, 4'b0010, 1'b0, 1'b0, 2};
      vecs[12] = '{4'd4,  8'hFF, 8'h00, 8'h0F, 4'b0000, 1'b0, 16'h00F0, 4'b1000, 1'b0, 1'b0, 2};
      vecs[13] = '{4'd7,  8'h81, 8'h00, 8'h00, 4'b0001, 1'b0, 16'h0040, 4'b0001, 1'b0, 1'b0, 2};
      vecs[14] = '{4'd6,  8'h80, 8'h00, 8'h00, 4'b0001, 1'b0, 16'h0001, 4'b0001, 1'b0, 1'b0, 2};
      vecs[15] = '{4'd10, 8'hFF, 8'h00, 8'h00, 4'b0000, 1'b0, 16'h0000, 4'b0010, 1'b0, 1'b0, 2};
      vecs[16] = '{4'd11, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b0, 16'h00FF, 4'b1001, 1'b0, 1'b0, 2};
      vecs[17] = '{4'd15, 8'h00, 8'h00, 8'h00, 4'b0010, 1'b0, 16'h0000, 4'b0010, 1'b0, 1'b1, 2};
      vecs[18] = '{4'd0,  8'h7F, 8'h00, 8'h01, 4'b0001, 1'b0, 16'h0081, 4'b1100, 1'b0, 1'b0, 2};

      rst = 1'b1; op_valid = 1'b0; op_code = 4'd0; operand_a = 8'h00;
      operand_a_hi = 8'h00; operand_b = 8'h00; flags_in = 4'h0; dec_flag = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_op_ready", 16'(op_ready), 16'd1);
      chk("rst_res_valid", 16'(res_valid), 16'd0);
      chk("rst_result", result, 16'h0000);
      chk("rst_flags_out", 16'(flags_out), 16'd0);
      chk("rst_page_cross", 16'(page_cross), 16'd0);
      chk("rst_illegal_op", 16'(illegal_op), 16'd0);
      chk("rst_alu_ctl", 16'(alu_ctl), 16'd0);
      chk("rst_alu_sb", 16'(alu_sb), 16'd0);
      rst = 1'b0;

      for (int i = 0; i < 19; i++) send(vecs[i]);
      drain();

      // Reset during ADDW EXEC_HI aborts the op with no result strobe.
      wait_ready();
      h = '{4'd12, 8'hF0, 8'h12, 8'h20, 4'b0000, 1'b0, 16'h0000, 4'b0000, 1'b0, 1'b0, 3};
      present(h);
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      @(negedge clk);
      chk("addw_lo_busy", 16'(op_ready), 16'd0);
      chk("addw_lo_ctl", 16'(alu_ctl), 16'h1440);
      chk("addw_lo_sb", 16'(alu_sb), 16'h00F0);
      chk("addw_lo_db", 16'(alu_db), 16'h0020);
      @(negedge clk);
      chk("addw_hi_ctl", 16'(alu_ctl), 16'h14C0);
      chk("addw_hi_sb", 16'(alu_sb), 16'h0012);
      chk("addw_hi_db", 16'(alu_db), 16'h0000);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_op_ready", 16'(op_ready), 16'd1);
      chk("abort_res_valid", 16'(res_valid), 16'd0);
      chk("abort_result", result, 16'h0000);
      chk("abort_alu_ctl", 16'(alu_ctl), 16'd0);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (res_valid) pulses++;
      end
      chk("abort_no_res_valid", 16'(pulses), 16'd0);

      // op_valid held with changing operands during EXEC is ignored.
      wait_ready();
      h = '{4'd1, 8'h10, 8'h00, 8'h05, 4'b0001, 1'b0, 16'h000B, 4'b0001, 1'b0, 1'b0, 2};
      send(h);
      op_valid = 1'b1; op_code = 4'd0; operand_a = 8'hFF; operand_b = 8'hFF; flags_in = 4'b1111;
      @(negedge clk);
      chk("hold_busy", 16'(op_ready), 16'd0);
      chk("hold_sbc_ctl", 16'(alu_ctl), 16'h24C2);
      chk("hold_sbc_sb", 16'(alu_sb), 16'h0010);
      @(negedge clk);
      op_valid = 1'b0;
      drain();
      repeat (4) @(negedge clk);
      chk("hold_idle_after", 16'(op_ready), 16'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end

endmodule
